ethernet_rx_frame_generator: RTL and testbench

Synthesizable, parametrised Ethernet frame source that drives the RX PHY-side interface (i_rx_phy_dv / i_rx_phy_data) of the ethernet interface top. It replaces hand-written byte arrays with run-time configurable frames. Frames are assembled from optional preamble/SFD, MAC header, length, and payload (incrementing, LFSR or constant), with optional padding and a computed CRC32 FCS. It supports multi-frame bursts with a programmable gap and deliberate FCS corruption for negative testing.

---
 rtl/ethernet_rx_frame_generator.sv | 192 +++++++++++++++++++
 tb/tb_ethernet_rx_frame_generator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_rx_frame_generator.sv
// Run-time configurable Ethernet frame source for the RX PHY interface.
// The FSM is one beat ahead of the registered o_phy_* outputs.
module ethernet_rx_frame_generator #(
  parameter int DATA_WIDTH     = 4,
  parameter int PREAMBLE_BYTES = 7,
  parameter int PAD_TO_MIN     = 1,
  parameter int MAX_PAYLOAD    = 1500
) (
  input  logic                  i_main_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [15:0]           i_frame_count,
  input  logic [15:0]           i_payload_size,
  input  logic [47:0]           i_dest_mac,
  input  logic [47:0]           i_src_mac,
  input  logic [1:0]            i_payload_mode,
  input  logic [7:0]            i_fill_byte,
  input  logic [31:0]           i_lfsr_seed,
  input  logic [15:0]           i_gap_count,
  input  logic                  i_corrupt_crc,
  output logic                  o_phy_dv,
  output logic [DATA_WIDTH-1:0] o_phy_data,
  output logic                  o_busy,
  output logic [15:0]           o_frames_sent,
  output logic                  o_done
);
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS, S_GAP
  } state_t;

  localparam state_t FIRST_ST = (PREAMBLE_BYTES == 0) ? S_HDR : S_PRE;

  state_t                state_q;
  logic [15:0]           cnt_q, count_q, size_q, gap_q, frames_q;
  logic                  phase_q, start_prev_q, fin_q, last_q;
  logic [31:0]           crc_q, lfsr_q;
  logic [47:0]           da_q, sa_q;
  logic [1:0]            mode_q;
  logic [7:0]            fill_q;
  logic                  corrupt_q;
  logic                  dv_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [111:0]          hdr;
  logic [6:0]            hdr_idx;
  logic [31:0]           fcs_v, crc_c, crc_d, lfsr_d;
  logic [7:0]            cur_byte, pay_byte;
  logic [DATA_WIDTH-1:0] beat;
  logic                  byte_done, need_pad, frame_last;
  state_t                after_pay, after_hdr, frame_next;

  always_comb begin
    hdr      = {da_q, sa_q, size_q};
    hdr_idx  = 7'd111 - {cnt_q[3:0], 3'b000};
    fcs_v    = ~crc_q ^ {31'b0, corrupt_q};
    case (mode_q)
      2'd1:    pay_byte = lfsr_q[7:0];
      2'd2:    pay_byte = fill_q;
      default: pay_byte = cnt_q[7:0];
    endcase
    cur_byte = '0;
    case (state_q)
      S_PRE:   cur_byte = 8'h55;
      S_SFD:   cur_byte = 8'hD5;
      S_HDR:   cur_byte = hdr[hdr_idx -: 8];
      S_PAY:   cur_byte = pay_byte;
      S_FCS:   cur_byte = fcs_v[{cnt_q[1:0], 3'b000} +: 8];
      default: cur_byte = '0;
    endcase
    if (DATA_WIDTH == 8) beat = DATA_WIDTH'(cur_byte);
    else                 beat = DATA_WIDTH'(phase_q ? cur_byte[7:4] : cur_byte[3:0]);
    byte_done = (DATA_WIDTH == 8) || phase_q;

    crc_c = crc_q ^ {24'h0, cur_byte};
    for (int unsigned i = 0; i < 8; i++)
      crc_c = crc_c[0] ? ((crc_c >> 1) ^ 32'hEDB88320) : (crc_c >> 1);
    crc_d  = crc_c;
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h80200003) : (lfsr_q >> 1);

    need_pad  = (PAD_TO_MIN != 0) && (size_q < 16'd46);
    after_pay = need_pad ? S_PAD : S_FCS;
    after_hdr = (size_q == 16'd0) ? after_pay : S_PAY;
    frame_last = 1'b0;
    frame_next = S_IDLE;
    case (state_q)
      S_PRE: begin frame_last = (cnt_q == 16'(PREAMBLE_BYTES - 1)); frame_next = S_SFD;     end
      S_SFD: begin frame_last = 1'b1;                               frame_next = S_HDR;     end
      S_HDR: begin frame_last = (cnt_q == 16'd13);                  frame_next = after_hdr; end
      S_PAY: begin frame_last = (cnt_q == size_q - 16'd1);          frame_next = after_pay; end
      S_PAD: begin frame_last = (cnt_q == 16'd45 - size_q);         frame_next = S_FCS;     end
      S_FCS: begin frame_last = (cnt_q == 16'd3);                   frame_next = S_GAP;     end
      default: ;
    endcase
  end

  always_ff @(posedge i_main_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      start_prev_q <= 1'b0;
      fin_q        <= 1'b0;
      last_q       <= 1'b0;
      crc_q        <= '1;
      lfsr_q       <= 32'h1;
      count_q      <= 16'd1;
      size_q       <= '0;
      gap_q        <= 16'd1;
      frames_q     <= '0;
      da_q         <= '0;
      sa_q         <= '0;
      mode_q       <= '0;
      fill_q       <= '0;
      corrupt_q    <= 1'b0;
      dv_q         <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_prev_q <= i_start;
      done_q       <= 1'b0;
      fin_q        <= 1'b0;
      // Frame completion is committed one cycle after the last gap cycle so
      // o_frames_sent/o_done appear only once the full gap has elapsed.
      if (fin_q) begin
        frames_q <= frames_q + 16'd1;
        if (last_q) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
      case (state_q)
        S_IDLE: begin
          dv_q   <= 1'b0;
          data_q <= '0;
          if (i_start && !start_prev_q && !busy_q) begin
            count_q   <= (i_frame_count == 16'd0) ? 16'd1 : i_frame_count;
            gap_q     <= (i_gap_count == 16'd0) ? 16'd1 : i_gap_count;
            size_q    <= (i_payload_size > 16'(MAX_PAYLOAD)) ? 16'(MAX_PAYLOAD) : i_payload_size;
            lfsr_q    <= (i_lfsr_seed == 32'd0) ? 32'h1 : i_lfsr_seed;
            da_q      <= i_dest_mac;
            sa_q      <= i_src_mac;
            mode_q    <= i_payload_mode;
            fill_q    <= i_fill_byte;
            corrupt_q <= i_corrupt_crc;
            busy_q    <= 1'b1;
            frames_q  <= '0;
            crc_q     <= '1;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            state_q   <= FIRST_ST;
          end
        end
        S_GAP: begin
          dv_q   <= 1'b0;
          data_q <= '0;
          if (cnt_q == gap_q - 16'd1) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            crc_q   <= '1;
            fin_q   <= 1'b1;
            last_q  <= (frames_q + 16'd1 == count_q);
            state_q <= (frames_q + 16'd1 == count_q) ? S_IDLE : FIRST_ST;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          dv_q    <= 1'b1;
          data_q  <= beat;
          phase_q <= (DATA_WIDTH == 8) ? 1'b0 : ~phase_q;
          if (byte_done) begin
            if (state_q == S_HDR || state_q == S_PAY || state_q == S_PAD) crc_q <= crc_d;
            if (state_q == S_PAY && mode_q == 2'd1) lfsr_q <= lfsr_d;
            if (frame_last) begin
              cnt_q   <= '0;
              state_q <= frame_next;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
      endcase
    end
  end

  assign o_phy_dv      = dv_q;
  assign o_phy_data    = data_q;
  assign o_busy        = busy_q;
  assign o_frames_sent = frames_q;
  assign o_done        = done_q;
endmodule

// File: tb/tb_ethernet_rx_frame_generator.sv
// Directed bench: a nibble-wide instance (no preamble/pad) and a byte-wide
// instance (preamble + padding), checked against a bench-side frame model.
module tb_ethernet_rx_frame_generator;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, rst8, start4, start8;
  logic [15:0] frame_count, payload_size, gap;
  logic [47:0] da, sa;
  logic [1:0]  mode;
  logic [7:0]  fill;
  logic [31:0] seed;
  logic        corrupt;

  logic        dv4, busy4, done4, dv8, busy8, done8;
  logic [3:0]  data4;
  logic [7:0]  data8;
  logic [15:0] fs4, fs8;

  ethernet_rx_frame_generator #(.DATA_WIDTH(4), .PREAMBLE_BYTES(0), .PAD_TO_MIN(0), .MAX_PAYLOAD(1500)) u4 (
    .i_main_clk(clk), .i_rst(rst4), .i_start(start4), .i_frame_count(frame_count),
    .i_payload_size(payload_size), .i_dest_mac(da), .i_src_mac(sa), .i_payload_mode(mode),
    .i_fill_byte(fill), .i_lfsr_seed(seed), .i_gap_count(gap), .i_corrupt_crc(corrupt),
    .o_phy_dv(dv4), .o_phy_data(data4), .o_busy(busy4), .o_frames_sent(fs4), .o_done(done4));

  ethernet_rx_frame_generator #(.DATA_WIDTH(8), .PREAMBLE_BYTES(7), .PAD_TO_MIN(1), .MAX_PAYLOAD(1500)) u8 (
    .i_main_clk(clk), .i_rst(rst8), .i_start(start8), .i_frame_count(frame_count),
    .i_payload_size(payload_size), .i_dest_mac(da), .i_src_mac(sa), .i_payload_mode(mode),
    .i_fill_byte(fill), .i_lfsr_seed(seed), .i_gap_count(gap), .i_corrupt_crc(corrupt),
    .o_phy_dv(dv8), .o_phy_data(data8), .o_busy(busy8), .o_frames_sent(fs8), .o_done(done8));

  int errors = 0;
  int checks = 0;

  // Capture state, owned by the monitor; cleared on request via clr.
  logic       clr = 1'b0;
  logic [7:0] q4[$], q8[$], exp_q[$];
  logic [3:0] lo4;
  int         dvc4, donec4, done_low4, low4, dvc8, donec8, low8;
  int         gaps8[$];
  logic       half4, seen8;
  logic [15:0] fsh8, fs8_prev;
  logic [31:0] mlfsr;

  always @(negedge clk) begin
    if (clr) begin
      q4.delete(); q8.delete(); gaps8.delete();
      dvc4 = 0; donec4 = 0; done_low4 = 0; low4 = 0; half4 = 1'b0;
      dvc8 = 0; donec8 = 0; low8 = 0; seen8 = 1'b0; fsh8 = '0;
    end else begin
      if (dv4) begin
        dvc4++;
        if (half4) begin q4.push_back({data4, lo4}); half4 = 1'b0; end
        else begin lo4 = data4; half4 = 1'b1; end
      end else half4 = 1'b0;
      if (done4) begin donec4++; done_low4 = low4; end
      low4 = dv4 ? 0 : low4 + 1;
      if (dv8) begin
        dvc8++;
        q8.push_back(data8);
        if (seen8 && low8 > 0) gaps8.push_back(low8);
        seen8 = 1'b1;
      end
      if (done8) donec8++;
      low8 = dv8 ? 0 : low8 + 1;
      if (fs8 != fs8_prev) fsh8 = {fsh8[11:0], fs8[3:0]};
    end
    fs8_prev = fs8;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Appends one expected frame (size already clamped) to exp_q.
  task automatic build(input int pre, input int size, input int padto);
    int hs;
    logic [31:0] c;
    for (int i = 0; i < pre; i++) exp_q.push_back(8'h55);
    if (pre > 0) exp_q.push_back(8'hD5);
    hs = exp_q.size();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(da >> (40 - 8 * i)));
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(sa >> (40 - 8 * i)));
    exp_q.push_back(8'(size >> 8));
    exp_q.push_back(8'(size));
    for (int k = 0; k < size; k++) begin
      case (mode)
        2'd1: begin
          exp_q.push_back(mlfsr[7:0]);
          mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 32'h80200003) : (mlfsr >> 1);
        end
        2'd2:    exp_q.push_back(fill);
        default: exp_q.push_back(8'(k));
      endcase
    end
    for (int k = size; k < padto; k++) exp_q.push_back(8'h00);
    c = '1;
    for (int i = hs; i < exp_q.size(); i++) c = crc_byte(c, exp_q[i]);
    c = ~c ^ {31'b0, corrupt};
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(c >> (8 * i)));
  endtask

  task automatic cmp_frame(input string tag, input bit use8);
    logic [7:0] got[$];
    int bad = 0;
    if (use8) got = q8; else got = q4;
    chk({tag, "_nbytes"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    chk({tag, "_badbytes"}, 64'(bad), 64'd0);
  endtask

  task automatic wait_done(input string tag, input bit use8, input int limit, input bit pulse);
    int d0;
    int n = 0;
    d0 = use8 ? donec8 : donec4;
    while ((use8 ? donec8 : donec4) == d0 && n < limit) begin
      if (pulse) start4 = (n % 300 == 150);
      tick();
      n++;
    end
    start4 = 1'b0;
    chk({tag, "_done_in_time"}, 64'(n < limit), 64'd1);
    repeat (3) tick();
  endtask

  task automatic set_known();
    da = 48'h1A2B3C4D5E6F; sa = 48'hFFFFFFFFFFFF; payload_size = 16'd12;
    mode = 2'd0; frame_count = 16'd1; gap = 16'd1; corrupt = 1'b0;
  endtask

  initial begin
    rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
    set_known(); fill = 8'h00; seed = 32'h0;
    repeat (3) tick();
    rst4 = 1'b0; rst8 = 1'b0;
    tick();

    chk("rst_dv4", dv4, 1'b0);
    chk("rst_data4", data4, 4'h0);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_fs4", fs4, 16'd0);
    chk("rst_done4", done4, 1'b0);
    chk("rst_dv8", dv8, 1'b0);
    chk("rst_busy8", busy8, 1'b0);

    // Known frame, nibble interface, start latency.
    clear();
    start4 = 1'b1;
    tick();
    chk("lat_busy", busy4, 1'b1);
    chk("lat_dv_low", dv4, 1'b0);
    start4 = 1'b0;
    tick();
    chk("lat_dv_high", dv4, 1'b1);
    wait_done("known", 1'b0, 500, 1'b0);
    exp_q.delete(); build(0, 12, 0);
    cmp_frame("known", 1'b0);
    chk("known_dvcycles", 64'(dvc4), 64'd60);
    chk("known_donecnt", 64'(donec4), 64'd1);
    chk("known_fs", fs4, 16'd1);
    chk("known_busy_end", busy4, 1'b0);
    chk("known_idle_before_done", 64'(done_low4), 64'd1);

    // Preamble and minimum-size padding, byte interface.
    payload_size = 16'd10;
    clear();
    start8 = 1'b1; tick(); start8 = 1'b0;
    wait_done("pad", 1'b1, 500, 1'b0);
    exp_q.delete(); build(7, 10, 46);
    cmp_frame("pad", 1'b1);
    chk("pad_dvcycles", 64'(dvc8), 64'd72);

    // Corrupted FCS: only bit 0 of the first FCS byte differs.
    corrupt = 1'b1;
    clear();
    start8 = 1'b1; tick(); start8 = 1'b0;
    wait_done("corrupt", 1'b1, 500, 1'b0);
    exp_q.delete(); build(7, 10, 46);
    cmp_frame("corrupt", 1'b1);
    corrupt = 1'b0;

    // Three-frame LFSR burst with a 12-cycle gap.
    frame_count = 16'd3; gap = 16'd12; mode = 2'd1; seed = 32'h01020304; payload_size = 16'd4;
    clear();
    start8 = 1'b1; tick(); start8 = 1'b0;
    wait_done("burst", 1'b1, 1000, 1'b0);
    exp_q.delete(); mlfsr = 32'h01020304;
    for (int f = 0; f < 3; f++) build(7, 4, 46);
    cmp_frame("burst", 1'b1);
    chk("burst_dvcycles", 64'(dvc8), 64'd216);
    chk("burst_ngaps", 64'(gaps8.size()), 64'd2);
    chk("burst_gap0", 64'(gaps8.size() > 0 ? gaps8[0] : -1), 64'd12);
    chk("burst_gap1", 64'(gaps8.size() > 1 ? gaps8[1] : -1), 64'd12);
    chk("burst_fs_steps", fsh8, 16'h0123);
    chk("burst_donecnt", 64'(donec8), 64'd1);
    chk("burst_fs_final", fs8, 16'd3);

    // Reset in the middle of payload byte 5, then a clean frame.
    set_known();
    clear();
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int n = 0; n < 200 && q4.size() < 19; n++) tick();
    chk("midrst_reached", 64'(q4.size()), 64'd19);
    rst4 = 1'b1;
    tick();
    chk("midrst_dv", dv4, 1'b0);
    chk("midrst_data", data4, 4'h0);
    chk("midrst_busy", busy4, 1'b0);
    chk("midrst_fs", fs4, 16'd0);
    rst4 = 1'b0;
    tick();
    clear();
    start4 = 1'b1; tick(); start4 = 1'b0;
    wait_done("after_rst", 1'b0, 500, 1'b0);
    exp_q.delete(); build(0, 12, 0);
    cmp_frame("after_rst", 1'b0);
    chk("after_rst_fs", fs4, 16'd1);

    // Zero count/gap, oversize payload clamped, start pulses while busy.
    frame_count = 16'd0; gap = 16'd0; payload_size = 16'd2000; mode = 2'd2; fill = 8'hA5;
    clear();
    start4 = 1'b1; tick(); start4 = 1'b0;
    wait_done("edge", 1'b0, 4000, 1'b1);
    exp_q.delete(); build(0, 1500, 0);
    cmp_frame("edge", 1'b0);
    chk("edge_len_field", (q4.size() > 13) ? {q4[12], q4[13]} : 16'hFFFF, 16'h05DC);
    chk("edge_dvcycles", 64'(dvc4), 64'd3036);
    chk("edge_idle_before_done", 64'(done_low4), 64'd1);
    chk("edge_fs", fs4, 16'd1);
    repeat (20) tick();
    chk("edge_donecnt", 64'(donec4), 64'd1);
    chk("edge_no_restart", 64'(dvc4), 64'd3036);
    chk("edge_busy_end", busy4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
